// File: rtl/shifter_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 32-bit logical-right
// shifter between two requesters; one operation in flight, result per port.
module shifter_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] dataA0,
  input  logic [31:0] dataA1,
  input  logic [4:0]  shamt0,
  input  logic [4:0]  shamt1,
  input  logic [5:0]  funct0,
  input  logic [5:0]  funct1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] result0,
  output logic [31:0] result1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] sh_dataA,
  output logic [31:0] sh_dataB,
  output logic [5:0]  sh_signal,
  input  logic [31:0] sh_dataOut
);

  localparam logic [5:0] SRL_FUNCT = 6'b000010;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [5:0]  funct_q, funct_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic [31:0] result0_q, result0_d, result1_q, result1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] sh_dataA_q, sh_dataA_d, sh_dataB_q, sh_dataB_d;
  logic [5:0]  sh_signal_q, sh_signal_d;

  logic        win_valid;
  logic        win_port;
  logic [5:0]  win_funct;
  logic        cap_err;
  logic [31:0] cap_result;

  // Under contention the port that did not win last time goes first.
  assign win_valid  = req0 | req1;
  assign win_port   = (req0 & req1) ? ~last_grant_q : ~req0;
  assign win_funct  = win_port ? funct1 : funct0;
  assign cap_err    = (funct_q != SRL_FUNCT);
  assign cap_result = cap_err ? 32'h0 : sh_dataOut;

  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path
    // through this block can leave one unassigned and infer a latch.
    state_d      = state_q;
    last_grant_d = last_grant_q;
    funct_d      = funct_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    result0_d    = result0_q;
    result1_d    = result1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;
    sh_dataA_d   = sh_dataA_q;
    sh_dataB_d   = sh_dataB_q;
    sh_signal_d  = 6'b000000;

    if (state_q == DRIVE) begin
      // The shifter output is settled by the end of DRIVE; last_grant names the owner.
      state_d = DONE;
      if (last_grant_q) begin
        result1_d = cap_result;
        err1_d    = cap_err;
        done1_d   = 1'b1;
      end else begin
        result0_d = cap_result;
        err0_d    = cap_err;
        done0_d   = 1'b1;
      end
    end else if (win_valid) begin
      state_d      = DRIVE;
      last_grant_d = win_port;
      funct_d      = win_funct;
      gnt0_d       = ~win_port;
      gnt1_d       = win_port;
      sh_dataA_d   = win_port ? dataA1 : dataA0;
      sh_dataB_d   = {27'b0, (win_port ? shamt1 : shamt0)};
      sh_signal_d  = (win_funct == SRL_FUNCT) ? SRL_FUNCT : 6'b000000;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample the values from
    // before the edge, independent of statement order.
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      funct_q      <= 6'b000000;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      result0_q    <= 32'h0;
      result1_q    <= 32'h0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      sh_dataA_q   <= 32'h0;
      sh_dataB_q   <= 32'h0;
      sh_signal_q  <= 6'b000000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      funct_q      <= funct_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      result0_q    <= result0_d;
      result1_q    <= result1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      sh_dataA_q   <= sh_dataA_d;
      sh_dataB_q   <= sh_dataB_d;
      sh_signal_q  <= sh_signal_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign result0   = result0_q;
  assign result1   = result1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign sh_dataA  = sh_dataA_q;
  assign sh_dataB  = sh_dataB_q;
  assign sh_signal = sh_signal_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Bench for shifter_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin / shift model.
module tb_shifter_arbiter;

  localparam logic [5:0] SRL = 6'b000010;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] dataA0, dataA1;
  logic [4:0]  shamt0, shamt1;
  logic [5:0]  funct0, funct1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] result0, result1;
  logic [31:0] sh_dataA, sh_dataB, sh_dataOut;
  logic [5:0]  sh_signal;

  int checks   = 0;
  int failures = 0;

  // Transaction-level model: who won last, what each port last returned,
  // and what the shifter inputs should be holding.
  int          model_last;
  logic [31:0] model_res [2];
  logic        model_err [2];
  logic [31:0] model_sha;
  logic [31:0] model_shb;

  // Pending request contents per port, as presented to the DUT.
  logic [31:0] op_data  [2];
  logic [4:0]  op_shamt [2];
  logic [5:0]  op_funct [2];

  shifter_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .dataA0(dataA0), .dataA1(dataA1),
    .shamt0(shamt0), .shamt1(shamt1),
    .funct0(funct0), .funct1(funct1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .result0(result0), .result1(result1),
    .err0(err0), .err1(err1),
    .sh_dataA(sh_dataA), .sh_dataB(sh_dataB),
    .sh_signal(sh_signal), .sh_dataOut(sh_dataOut)
  );

  always #5 clk = ~clk;

  // External shifter stand-in; garbage unless asked to shift.
  assign sh_dataOut = (sh_signal == SRL) ? (sh_dataA >> sh_dataB[4:0]) : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] d, input logic [4:0] s,
                          input logic [5:0] f, input logic r);
    op_data[p]  = d;
    op_shamt[p] = s;
    op_funct[p] = f;
    if (p == 0) begin
      dataA0 = d; shamt0 = s; funct0 = f; req0 = r;
    end else begin
      dataA1 = d; shamt1 = s; funct1 = f; req1 = r;
    end
  endtask

  task automatic drop_req(input int p);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  function automatic logic [5:0] rand_funct();
    logic [5:0] f;
    f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : SRL;
    return f;
  endfunction

  task automatic model_reset();
    model_last   = 1;
    model_res[0] = 32'h0;
    model_res[1] = 32'h0;
    model_err[0] = 1'b0;
    model_err[1] = 1'b0;
    model_sha    = 32'h0;
    model_shb    = 32'h0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_reset();
  endtask

  // One full operation starting at the next arbitration edge: grant cycle, then done cycle.
  task automatic serve_op(input bit hold);
    int          w;
    logic [31:0] exp_res;
    logic        exp_err;
    logic [5:0]  exp_sig;
    logic [3:0]  exp_p;
    w       = (req0 && req1) ? 1 - model_last : (req0 ? 0 : 1);
    exp_err = (op_funct[w] != SRL);
    exp_res = exp_err ? 32'h0 : (op_data[w] >> op_shamt[w]);
    exp_sig = exp_err ? 6'b000000 : SRL;
    model_sha = op_data[w];
    model_shb = {27'b0, op_shamt[w]};
    tick();
    exp_p = {w == 0, w == 1, 2'b00};
    checks++;
    if ({gnt0, gnt1, done0, done1} !== exp_p) begin
      failures++;
      $display("FAIL grant_pulses: got gnt0,gnt1,done0,done1=%b want %b", {gnt0, gnt1, done0, done1}, exp_p);
    end
    checks++;
    if (sh_signal !== exp_sig || sh_dataA !== model_sha || sh_dataB !== model_shb) begin
      failures++;
      $display("FAIL drive_operands: got sig=%b A=%h B=%h want sig=%b A=%h B=%h",
               sh_signal, sh_dataA, sh_dataB, exp_sig, model_sha, model_shb);
    end
    model_last = w;
    if (hold) set_port(w, $urandom, 5'($urandom_range(0, 31)), rand_funct(), 1'b1);
    else      drop_req(w);
    tick();
    exp_p = {2'b00, w == 0, w == 1};
    checks++;
    if ({gnt0, gnt1, done0, done1} !== exp_p) begin
      failures++;
      $display("FAIL done_pulses: got gnt0,gnt1,done0,done1=%b want %b", {gnt0, gnt1, done0, done1}, exp_p);
    end
    model_res[w] = exp_res;
    model_err[w] = exp_err;
    checks++;
    if (result0 !== model_res[0] || err0 !== model_err[0] ||
        result1 !== model_res[1] || err1 !== model_err[1]) begin
      failures++;
      $display("FAIL results: got r0=%h e0=%b r1=%h e1=%b want r0=%h e0=%b r1=%h e1=%b",
               result0, err0, result1, err1, model_res[0], model_err[0], model_res[1], model_err[1]);
    end
    checks++;
    if (sh_signal !== 6'b000000) begin
      failures++;
      $display("FAIL signal_after_drive: got %b want 000000", sh_signal);
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if ({gnt0, gnt1, done0, done1} !== 4'b0000 || sh_signal !== 6'b000000 ||
          sh_dataA !== model_sha || sh_dataB !== model_shb) begin
        failures++;
        $display("FAIL idle: got pulses=%b sig=%b A=%h B=%h want 0000 000000 A=%h B=%h",
                 {gnt0, gnt1, done0, done1}, sh_signal, sh_dataA, sh_dataB, model_sha, model_shb);
      end
    end
  endtask

  task automatic check_all_reset(input string tag);
    checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1} !== 6'b0 || result0 !== 32'h0 || result1 !== 32'h0 ||
        sh_dataA !== 32'h0 || sh_dataB !== 32'h0 || sh_signal !== 6'b0) begin
      failures++;
      $display("FAIL %s: got flags=%b r0=%h r1=%h A=%h B=%h sig=%b want all zero", tag,
               {gnt0, gnt1, done0, done1, err0, err1}, result0, result1, sh_dataA, sh_dataB, sh_signal);
    end
  endtask

  task automatic test_reset();
    set_port(0, 32'h0, 5'd0, SRL, 1'b0);
    set_port(1, 32'h0, 5'd0, SRL, 1'b0);
    reset = 1'b0;
    tick();
    check_all_reset("reset_values");
    req0 = 1'b1;
    tick();
    check_all_reset("reset_overrides_req");
    req0 = 1'b0;
    reset = 1'b1;
    model_reset();
    idle_ticks(1);
  endtask

  task automatic test_single();
    set_port(0, 32'hF000_000F, 5'd4, SRL, 1'b1);
    serve_op(0);
    checks++;
    if (result0 !== 32'h0F00_0000 || err0 !== 1'b0) begin
      failures++;
      $display("FAIL single_srl: got r0=%h e0=%b want 0f000000 0", result0, err0);
    end
    idle_ticks(2);
  endtask

  task automatic test_contention();
    apply_reset();
    set_port(0, 32'h8000_0000, 5'd1, SRL, 1'b1);
    set_port(1, 32'h8000_0000, 5'd3, SRL, 1'b1);
    serve_op(0);
    serve_op(0);
    checks++;
    if (result0 !== 32'h4000_0000 || result1 !== 32'h1000_0000) begin
      failures++;
      $display("FAIL contention_results: got r0=%h r1=%h want 40000000 10000000", result0, result1);
    end
    idle_ticks(1);
  endtask

  task automatic test_back_to_back();
    int first;
    set_port(0, $urandom, 5'($urandom_range(0, 31)), SRL, 1'b1);
    set_port(1, $urandom, 5'($urandom_range(0, 31)), SRL, 1'b1);
    first = 1 - model_last;
    for (int i = 0; i < 6; i++) begin
      serve_op(1);
      checks++;
      if (model_last != ((first + i) % 2)) begin
        failures++;
        $display("FAIL alternation: op %0d went to port %0d want %0d", i, model_last, (first + i) % 2);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    idle_ticks(1);
  endtask

  task automatic test_bad_funct();
    logic [31:0] keep0;
    keep0 = model_res[0];
    set_port(1, $urandom, 5'($urandom_range(0, 31)), 6'b100000, 1'b1);
    serve_op(0);
    checks++;
    if (err1 !== 1'b1 || result1 !== 32'h0 || result0 !== keep0) begin
      failures++;
      $display("FAIL bad_funct: got e1=%b r1=%h r0=%h want 1 00000000 %h", err1, result1, result0, keep0);
    end
    idle_ticks(1);
  endtask

  task automatic test_shamt_bounds();
    logic [4:0]  amt [3];
    logic [31:0] want [3];
    amt  = '{5'd0, 5'd15, 5'd31};
    want = '{32'hFFFF_FFFF, 32'h0001_FFFF, 32'h0000_0001};
    for (int i = 0; i < 3; i++) begin
      set_port(0, 32'hFFFF_FFFF, amt[i], SRL, 1'b1);
      serve_op(0);
      checks++;
      if (result0 !== want[i]) begin
        failures++;
        $display("FAIL shamt_%0d: got %h want %h", amt[i], result0, want[i]);
      end
    end
    idle_ticks(1);
  endtask

  task automatic test_reset_in_drive();
    set_port(0, $urandom, 5'($urandom_range(0, 31)), SRL, 1'b1);
    tick();
    checks++;
    if (gnt0 !== 1'b1) begin
      failures++;
      $display("FAIL drive_entry: got gnt0=%b want 1", gnt0);
    end
    reset = 1'b0;
    tick();
    check_all_reset("reset_in_drive");
    reset = 1'b1;
    model_reset();
    set_port(1, $urandom, 5'($urandom_range(0, 31)), SRL, 1'b1);
    tick();
    checks++;
    if ({gnt0, gnt1, done0, done1} !== 4'b1000) begin
      failures++;
      $display("FAIL post_reset_contention: got gnt0,gnt1,done0,done1=%b want 1000", {gnt0, gnt1, done0, done1});
    end
    // Finish the restarted operation and the pending port 1 request through the model.
    req0 = 1'b0;
    model_last = 0;
    model_sha  = op_data[0];
    model_shb  = {27'b0, op_shamt[0]};
    tick();
    model_res[0] = op_data[0] >> op_shamt[0];
    checks++;
    if (done0 !== 1'b1 || result0 !== model_res[0]) begin
      failures++;
      $display("FAIL post_reset_op: got done0=%b r0=%h want 1 %h", done0, result0, model_res[0]);
    end
    serve_op(0);
    idle_ticks(1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if (!req0 && ($urandom_range(0, 1) == 1 || !req1))
        set_port(0, $urandom, 5'($urandom_range(0, 31)), rand_funct(), 1'b1);
      if (!req1 && $urandom_range(0, 1) == 1)
        set_port(1, $urandom, 5'($urandom_range(0, 31)), rand_funct(), 1'b1);
      serve_op(0);
      if (!req0 && !req1 && $urandom_range(0, 1) == 1) idle_ticks(1);
    end
    for (int i = 0; i < 2 && (req0 || req1); i++) serve_op(0);
    idle_ticks(1);
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_bad_funct();
    test_shamt_bounds();
    test_reset_in_drive();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
